pipeline_ctrl: RTL

- Central hazard and stall sequencer for the 5-stage pipeline.
- Drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC write enable.
- Arbitrates between four conditions: icache wait, dcache wait, load-use hazard and taken-branch flush.
- Sits in the datapath top beside the PC; owns the halt drain.

---
 rtl/cpu_types_pkg.sv | 62 ++++++
 rtl/pipe_perf_cnt.sv | 22 ++
 rtl/pipeline_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline-control state and latch-control bundle.
// Pure declarations plus one helper; no logic of its own.
// Consumed by pipeline_ctrl and its perf counters.
package cpu_types_pkg;

  // Register-file index width and type used by the decode/hazard paths.
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  // Default width of each pipeline performance counter.
  localparam int PERF_W = 32;

  // Pipeline sequencer states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_t;

  // Enables and bubble-loads for the PC and the four stage latches.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } pipe_latch_ctrl_t;

  // Latch pattern for a cycle in which the pipeline is allowed to move.
  // A taken branch squashes IF/ID and ID/EX and wins over a load-use stall,
  // because the younger instruction that caused the hazard is discarded anyway.
  // A load-use hazard freezes PC and IF/ID and drops one bubble into ID/EX.
  function automatic pipe_latch_ctrl_t adv_pattern(input logic br_taken, input logic ldu);
    pipe_latch_ctrl_t p;
    p = '0;
    if (br_taken) begin
      p.pc_en      = 1'b1;
      p.ifid_en    = 1'b1;
      p.ifid_flush = 1'b1;
      p.idex_en    = 1'b1;
      p.idex_flush = 1'b1;
      p.exmem_en   = 1'b1;
      p.memwb_en   = 1'b1;
    end else if (ldu) begin
      p.idex_en    = 1'b1;
      p.idex_flush = 1'b1;
      p.exmem_en   = 1'b1;
      p.memwb_en   = 1'b1;
    end else begin
      p.pc_en    = 1'b1;
      p.ifid_en  = 1'b1;
      p.idex_en  = 1'b1;
      p.exmem_en = 1'b1;
      p.memwb_en = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Single saturating event counter, cleared by reset.
// Counts the cycle after inc is sampled high; holds at all-ones once saturated.
// No backpressure; inc is a plain per-cycle event strobe.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Increment on each event until every bit is set, then stick there.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer: drives PC write enable plus enable/flush of IF/ID, ID/EX, EX/MEM, MEM/WB.
// Zero latency: all latch controls are combinational from state and current inputs.
// Stalls the whole pipe on icache/dcache wait; optional perf counters with PIPE_PERF_EN.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int RB_W = REG_W
`ifdef PIPE_PERF_EN
  ,
  parameter int PERF_W = cpu_types_pkg::PERF_W
`endif
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dreq,
  input  logic [RB_W-1:0] id_rs,
  input  logic [RB_W-1:0] id_rt,
  input  logic            ex_memread,
  input  logic [RB_W-1:0] ex_rd,
  input  logic            ex_br_taken,
  input  logic            wb_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            memwb_flush,
  output logic            halt,
  output logic [1:0]      ctrl_state
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] ldu_cnt
`endif
);

  pipe_ctrl_state_t state, state_nxt;
  pipe_latch_ctrl_t lc;
  logic             dhit_seen;
  logic             seen_set;
  logic             adv_fire;
  logic             dmem_ok;
  logic             adv;
  logic             ldu;

  // dhit_seen remembers a finished MEM access while the icache is still missing,
  // so the dcache is not asked again when the pipe finally moves.
  assign dmem_ok = !mem_dreq || dhit || dhit_seen;
  assign adv     = ihit && dmem_ok;
  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign ldu     = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

  // Next-state and latch control; all outputs forced to zero while reset is held.
  always_comb begin
    lc        = '0;
    state_nxt = state;
    seen_set  = 1'b0;
    adv_fire  = 1'b0;
    if (nRST) begin
      case (state)
        RUN: begin
          if (!dmem_ok) begin
            state_nxt = DWAIT;
          end else if (ihit) begin
            adv_fire = 1'b1;
          end
        end
        DWAIT: begin
          if (dhit) begin
            state_nxt = RUN;
            if (ihit) begin
              adv_fire = 1'b1;
            end else begin
              // EX/MEM is held but its access is done: push a bubble into WB
              // so the retiring instruction is not written back twice.
              seen_set       = 1'b1;
              lc.memwb_en    = 1'b1;
              lc.memwb_flush = 1'b1;
            end
          end
        end
        HALTED: begin
          state_nxt = HALTED;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
      if (adv_fire) begin
        lc = adv_pattern(ex_br_taken, ldu);
      end
      // HALT only counts once it actually retires into WB.
      if (wb_halt && lc.memwb_en) begin
        state_nxt = HALTED;
      end
    end
  end

  // State register and completed-MEM-access flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      dhit_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (seen_set) begin
        dhit_seen <= 1'b1;
      end else if (adv) begin
        dhit_seen <= 1'b0;
      end
    end
  end

  assign pc_en       = lc.pc_en;
  assign ifid_en     = lc.ifid_en;
  assign idex_en     = lc.idex_en;
  assign exmem_en    = lc.exmem_en;
  assign memwb_en    = lc.memwb_en;
  assign ifid_flush  = lc.ifid_flush;
  assign idex_flush  = lc.idex_flush;
  assign memwb_flush = lc.memwb_flush;
  assign halt        = (state == HALTED);
  assign ctrl_state  = state;

`ifdef PIPE_PERF_EN
  logic stall_inc;
  logic flush_inc;
  logic ldu_inc;

  assign stall_inc = nRST && (state != HALTED) && !lc.pc_en;
  assign flush_inc = adv_fire && ex_br_taken;
  assign ldu_inc   = adv_fire && !ex_br_taken && ldu;

  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_ldu_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (ldu_inc),
    .cnt  (ldu_cnt)
  );
`endif

endmodule
